// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Scans a parallel WIDTH-bit word MSB-first, one bit per clock,
//               through an embedded overlapping "101" Moore detector and
//               reports the number of detections with a one-cycle done pulse.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, data_in    - scan request and word (IDLE/DONE only)
//               abort             - cancel the scan in progress (SHIFT only)
//               busy, done        - scanning / one-cycle completion pulse
//               match_count       - detections in the last completed word
//               det_out           - detector Moore output (state D)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    match_count,
    output logic             det_out
);

    // Controller states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // Detector states
    localparam logic [1:0] c_det_a = 2'd0;
    localparam logic [1:0] c_det_b = 2'd1;
    localparam logic [1:0] c_det_c = 2'd2;
    localparam logic [1:0] c_det_d = 2'd3;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [1:0]       r_det;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    r_match_cnt;
    logic [CW-1:0]    r_match_count;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [1:0]       w_det_nxt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [CW-1:0]    w_match_cnt_nxt;
    logic [CW-1:0]    w_match_count_nxt;

    logic             w_bit;
    logic [1:0]       w_det_step;
    logic [CW-1:0]    w_match_inc;

    // One detector step on the current MSB
    always_comb begin
        w_bit      = r_shift[WIDTH-1];
        w_det_step = c_det_a;
        case (r_det)
            c_det_a: w_det_step = w_bit ? c_det_b : c_det_a;
            c_det_b: w_det_step = w_bit ? c_det_b : c_det_c;
            c_det_c: w_det_step = w_bit ? c_det_d : c_det_a;
            c_det_d: w_det_step = w_bit ? c_det_b : c_det_c;
            default: w_det_step = c_det_a;
        endcase
        // Count on entry to D so the final bit of the word is included
        w_match_inc = r_match_cnt + {{(CW-1){1'b0}}, (w_det_step == c_det_d)};
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_nxt       = r_shift;
        w_det_nxt         = r_det;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_match_cnt_nxt   = r_match_cnt;
        w_match_count_nxt = r_match_count;

        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt     = c_st_shift;
                    w_shift_nxt     = data_in;
                    w_det_nxt       = c_det_a;
                    w_bit_cnt_nxt   = '0;
                    w_match_cnt_nxt = '0;
                end else if (r_state == c_st_done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_shift: begin
                if (abort) begin
                    // Abort wins over start; the reported count is untouched
                    w_state_nxt = c_st_idle;
                    w_det_nxt   = c_det_a;
                end else begin
                    w_det_nxt       = w_det_step;
                    w_shift_nxt     = {r_shift[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                    w_match_cnt_nxt = w_match_inc;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt       = c_st_done;
                        w_match_count_nxt = w_match_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_det_nxt   = c_det_a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_shift       <= '0;
            r_det         <= c_det_a;
            r_bit_cnt     <= '0;
            r_match_cnt   <= '0;
            r_match_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_det         <= w_det_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_match_cnt   <= w_match_cnt_nxt;
            r_match_count <= w_match_count_nxt;
        end
    end

    // Outputs are pure decodes of registered state
    assign busy        = (r_state == c_st_shift);
    assign done        = (r_state == c_st_done);
    assign det_out     = (r_det == c_det_d);
    assign match_count = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_scan_ctrl
// Description : Self-checking bench for seq_scan_ctrl. Expected values come
//               from counting "101" substrings in the consumed bit string.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_count;
    logic          det_out;

    int n_vec;
    int n_err;
    int exp_mc;

    seq_scan_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .det_out     (det_out)
    );

    always #5 clk = ~clk;

    // Overlapping "101" occurrences among the first n bits, MSB first
    function automatic int ref_matches(input logic [W-1:0] w, input int n);
        int cnt;
        cnt = 0;
        for (int i = 2; i < n; i++) begin
            if (w[W-1-(i-2)] && !w[W-1-(i-1)] && w[W-1-i]) cnt++;
        end
        return cnt;
    endfunction

    // Detector output after n bits: the n-th bit completed a match
    function automatic int det_ref(input logic [W-1:0] w, input int n);
        if (n < 3) return 0;
        return (ref_matches(w, n) != ref_matches(w, n - 1)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a scan of w; optional abort/reset/start pulse at a SHIFT cycle.
    // hold keeps start high for a back-to-back start from DONE.
    task automatic run_scan(input logic [W-1:0] w, input int abort_at,
                            input int rst_at, input int start_at,
                            input bit hold, input bit noise);
        start   = 1'b1;
        data_in = w;
        @(posedge clk); #1;
        start   = hold;
        data_in = W'($urandom);
        for (int c = 1; c <= W; c++) begin
            chk("busy_shift", 32'(busy), 1);
            chk("done_shift", 32'(done), 0);
            chk("det_shift", 32'(det_out), det_ref(w, c - 1));
            if (!hold) start = (c == start_at) || (noise && ($urandom_range(0, 1) == 1));
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            rst   = 1'b0;
            if (c == abort_at || c == rst_at) begin
                start = 1'b0;
                if (c == rst_at) exp_mc = 0;
                chk("busy_cancel", 32'(busy), 0);
                chk("done_cancel", 32'(done), 0);
                chk("det_cancel", 32'(det_out), 0);
                chk("mc_cancel", 32'(match_count), exp_mc);
                @(posedge clk); #1;
                chk("busy_after_cancel", 32'(busy), 0);
                chk("done_after_cancel", 32'(done), 0);
                return;
            end
        end
        exp_mc = ref_matches(w, W);
        chk("done_pulse", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("mc_done", 32'(match_count), exp_mc);
        chk("det_done", 32'(det_out), det_ref(w, W));
        if (!hold) begin
            start = 1'b0;
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("mc_hold", 32'(match_count), exp_mc);
            chk("det_hold", 32'(det_out), det_ref(w, W));
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        start   = 1'b1;
        abort   = 1'b0;
        data_in = 8'hA5;
        n_vec   = 0;
        n_err   = 0;
        exp_mc  = 0;

        // Reset dominates a concurrent start
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mc", 32'(match_count), 0);
        chk("rst_det", 32'(det_out), 0);
        rst   = 1'b0;
        start = 1'b0;

        // Abort outside SHIFT is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 0);
        chk("abort_idle_done", 32'(done), 0);

        // Directed words
        run_scan(8'b10101010, 0, 0, 0, 1'b0, 1'b0);
        run_scan(8'hFF,       0, 0, 0, 1'b0, 1'b0);
        run_scan(8'h00,       0, 0, 0, 1'b0, 1'b0);
        run_scan(8'b01010101, 0, 0, 0, 1'b0, 1'b0);
        run_scan(8'b10100000, 0, 0, 0, 1'b0, 1'b0);

        // Back-to-back starts from DONE
        run_scan(8'b10110101, 0, 0, 0, 1'b1, 1'b0);
        run_scan(8'h00,       0, 0, 0, 1'b0, 1'b0);

        // Start while busy ignored, then abort
        run_scan(8'b10101010, 4, 0, 3, 1'b0, 1'b0);
        // Reset mid-scan, then a clean scan
        run_scan(8'b10101010, 0, 5, 0, 1'b0, 1'b0);
        run_scan(8'b01010101, 0, 0, 0, 1'b0, 1'b0);

        // Randomized words, aborts and back-to-back starts
        for (int k = 0; k < 60; k++) begin
            logic [W-1:0] w;
            int           ab;
            bit           hd;
            w  = W'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
            hd = (ab == 0) && ($urandom_range(0, 2) == 0);
            run_scan(w, ab, 0, 0, hd, 1'b1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences the team's 4-state overlapping "101" Moore sequence detector over a parallel data word. On a start request it latches a WIDTH-bit word, feeds it MSB-first, one bit per clock, into an embedded copy of the detector state machine, and counts the number of detections. It then reports the count with a one-cycle done pulse. The block sits between a parallel producer and any consumer that needs per-word "101" match statistics, and keeps the serial detector fully occupied under a start/busy/done handshake.

## Interface
- WIDTH, 8: bits per scanned word; legal range 3..32.
- CW, $clog2(WIDTH+1): width of match_count.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to scan data_in; sampled only in IDLE or DONE.
- abort  input  1  cancels a scan in progress; sampled only in SHIFT.
- data_in  input  WIDTH  word to scan; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a scan completes.
- match_count  output  CW  number of "101" detections in the last completed word.
- det_out  output  1  embedded detector Moore output: high when its state is D.

## Operation
- Controller FSM states:
  - IDLE: start=1 goes to SHIFT.
  - SHIFT: counts WIDTH bit cycles. After the last bit it goes to DONE. abort=1 goes to IDLE.
  - DONE: start=1 goes to SHIFT. Otherwise it goes to IDLE.
- Start acceptance, on the edge where start=1 in IDLE or DONE:
  - shift register <= data_in.
  - detector state <= A.
  - bit counter <= 0.
  - match counter <= 0.
- Each SHIFT cycle:
  - The current bit b is the shift register MSB.
  - The detector state advances: A: b?B:A; B: b?B:C; C: b?D:A; D: b?B:C.
  - The shift register shifts left by one.
  - The bit counter increments.
  - The match counter increments if the next detector state is D.
- Detection overlaps: the input 10101 gives 2 matches. Detector state does not carry across words.
- match_count is loaded from the match counter when DONE is entered. It holds until the next DONE or reset; it is not cleared by a start.
- abort in SHIFT:
  - Returns to IDLE on the next edge.
  - Detector state goes to A.
  - No done pulse is produced.
  - match_count keeps its previous value.
- start while in SHIFT is ignored, with no queuing. abort outside SHIFT is ignored.
- If start and abort are both high in SHIFT, abort wins and start is ignored.
- Reset values: busy=0, done=0, match_count=0, det_out=0, FSM=IDLE, detector=A, all internal counters 0.
- Reset takes priority over every other input, including during SHIFT. Reset mid-scan discards the scan with no done pulse.

## Timing
- Edge 0: start sampled high, word captured.
- Cycles 1..WIDTH: busy=1, one bit consumed per cycle.
- Cycle WIDTH+1: done=1, busy=0, and match_count is valid at the same time as done.
- Latency from the start edge to done high is WIDTH+1 cycles.
- Maximum throughput is one word every WIDTH+1 cycles, using back-to-back starts issued in DONE.
- det_out is registered. It is high in the cycle after a bit that drives the detector into D.
- The detector state stays as it was at the end of the scan through DONE and IDLE. It is reset to A only by a start, an abort or rst.
- The match count never overflows: the maximum is floor((WIDTH-1)/2), which is below 2^CW.

## Test plan
- Reset, then start with data_in=8'b10101010, i.e. bits 1,0,1,0,1,0,1,0. Expect busy high for 8 cycles, done at edge 9, match_count=3, and det_out pulsing high 3 times.
- data_in=8'hFF, then 8'h00. Expect match_count=0 and det_out never high for both words.
- data_in=8'b01010101: the match on the final bit must be counted, giving match_count=3. Then data_in=8'b10100000, giving match_count=1.
- Back-to-back: start held high through DONE, first word 8'b10110101 and second 8'h00. Expect done at edges 9 and 18, with match_count 3 then 0, and busy=0 for exactly one cycle between the scans.
- Abort and start-while-busy: start with 8'b10101010; pulse start at cycle 3 (ignored); assert abort at cycle 4. Expect IDLE at the next edge, no done, and match_count unchanged from the previous value.
- Reset mid-scan: assert rst at cycle 5 of a scan. Expect all outputs 0 on the next edge and no done. A new start then produces correct results.
